// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: default widths, opcode field geometry and
// the per-edge action priority (reset > redirect > stall > advance).
package fetch_stage_pkg;

  localparam int FS_ADDR_W = 8;
  localparam int FS_INST_W = 16;
  localparam int OPC_W     = 4;   // opcode sits in the top OPC_W bits of inst

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_STALL   = 2'd1,
    ACT_FLUSH   = 2'd2,
    ACT_RESET   = 2'd3
  } fetch_act_e;

  function automatic fetch_act_e fetch_action(input logic rst,
                                              input logic redirect,
                                              input logic stall);
    if (rst)           return ACT_RESET;
    else if (redirect) return ACT_FLUSH;
    else if (stall)    return ACT_STALL;
    else               return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/fetch_hold.sv
// One-entry hold buffer: captures the in-flight memory word on the first stall
// edge, releases it on the next advance, and is cleared by flush or reset.
module fetch_hold
  import fetch_stage_pkg::*;
#(
  parameter int INST_W = FS_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              f_valid,
  input  logic [INST_W-1:0] rdata,
  output logic [INST_W-1:0] inst,
  output logic              valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      inst  <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (stall) begin
      // Only the first stall edge captures; later ones keep the original word.
      if (!valid && f_valid) begin
        inst  <= rdata;
        valid <= 1'b1;
      end
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID register over a 1-cycle synchronous-read memory.
// IF/ID latency 2 edges from PC; stall freezes PC and IF/ID, redirect costs 2 bubbles.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          ADDR_W   = FS_ADDR_W,
  parameter int          INST_W   = FS_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              id_valid,
  output logic [INST_W-1:0] id_inst,
  output logic [OPC_W-1:0]  id_opcode,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus1
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] f_pc;
  logic              f_valid;
  logic [INST_W-1:0] h_inst;
  logic              h_valid;
  fetch_act_e        act;

  assign act = fetch_action(rst, redirect, stall);

  fetch_hold #(
    .INST_W (INST_W)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .flush   (act == ACT_FLUSH),
    .stall   (act == ACT_STALL),
    .f_valid (f_valid),
    .rdata   (imem_rdata),
    .inst    (h_inst),
    .valid   (h_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      f_pc     <= '0;
      f_valid  <= 1'b0;
      id_valid <= 1'b0;
      id_inst  <= '0;
      id_pc    <= '0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          pc       <= redirect_pc;
          f_valid  <= 1'b0;
          id_valid <= 1'b0;
        end
        ACT_STALL: begin
        end
        default: begin
          // While the hold buffer is full, imem_rdata is mem[pc] and is re-fetched below.
          id_inst  <= h_valid ? h_inst : imem_rdata;
          id_pc    <= f_pc;
          id_valid <= h_valid | f_valid;
          f_pc     <= pc;
          f_valid  <= 1'b1;
          pc       <= pc + ADDR_W'(1);
        end
      endcase
    end
  end

  assign imem_addr   = pc;
  assign id_opcode   = id_inst[INST_W-1 -: OPC_W];
  assign id_pc_plus1 = id_pc + ADDR_W'(1);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a synchronous-read memory holding 16'h1000+addr.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        id_valid;
  logic [15:0] id_inst;
  logic [3:0]  id_opcode;
  logic [7:0]  id_pc;
  logic [7:0]  id_pc_plus1;

  int n_cmp = 0;
  int n_err = 0;

  fetch_stage #(
    .ADDR_W   (8),
    .INST_W   (16),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_inst     (id_inst),
    .id_opcode   (id_opcode),
    .id_pc       (id_pc),
    .id_pc_plus1 (id_pc_plus1)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_val(input logic [7:0] a);
    return 16'h1000 + {8'h00, a};
  endfunction

  always @(posedge clk) imem_rdata <= mem_val(imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    step(); step();
    n_cmp++;
    if ({id_valid, id_pc, id_inst, imem_addr} !== {1'b0, 8'h00, 16'h0000, 8'h00}) begin
      n_err++;
      $display("FAIL reset_state: got v=%b pc=%h inst=%h addr=%h, want v=0 pc=00 inst=0000 addr=00",
               id_valid, id_pc, id_inst, imem_addr);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_edge1_valid: got %b, want 0", id_valid);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      logic [7:0] ep;
      ep = 8'(i);
      step();
      n_cmp++;
      if ({id_valid, id_pc, id_inst, id_opcode} !== {1'b1, ep, mem_val(ep), 4'h1}) begin
        n_err++;
        $display("FAIL stream[%0d]: got v=%b pc=%h inst=%h opc=%h, want v=1 pc=%h inst=%h opc=1",
                 i, id_valid, id_pc, id_inst, id_opcode, ep, mem_val(ep));
      end
    end
  endtask

  // Entered with id_pc=5 showing.
  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({id_valid, id_pc, id_inst} !== {1'b1, 8'h05, 16'h1005}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h inst=%h, want v=1 pc=05 inst=1005",
                 i, id_valid, id_pc, id_inst);
      end
    end
    stall = 1'b0;
    for (int i = 6; i <= 8; i++) begin
      logic [7:0] ep;
      ep = 8'(i);
      step();
      n_cmp++;
      if ({id_valid, id_pc, id_inst} !== {1'b1, ep, mem_val(ep)}) begin
        n_err++;
        $display("FAIL stall_resume[%0d]: got v=%b pc=%h inst=%h, want v=1 pc=%h inst=%h",
                 i, id_valid, id_pc, id_inst, ep, mem_val(ep));
      end
    end
  endtask

  // Issues a redirect on the next edge (with the given stall level) and checks
  // two bubbles followed by target and target+1.
  task automatic test_redirect(input logic [7:0] tgt, input logic with_stall, input string tag);
    logic [7:0] ep;
    redirect = 1'b1; redirect_pc = tgt; stall = with_stall;
    step();
    redirect = 1'b0; stall = 1'b0;
    n_cmp++;
    if (id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_bubble0: got v=%b pc=%h, want v=0", tag, id_valid, id_pc);
    end
    step();
    n_cmp++;
    if (id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_bubble1: got v=%b pc=%h, want v=0", tag, id_valid, id_pc);
    end
    for (int i = 0; i < 2; i++) begin
      ep = tgt + 8'(i);
      step();
      n_cmp++;
      if ({id_valid, id_pc, id_inst, id_pc_plus1} !== {1'b1, ep, mem_val(ep), ep + 8'h01}) begin
        n_err++;
        $display("FAIL %s_target[%0d]: got v=%b pc=%h inst=%h p1=%h, want v=1 pc=%h inst=%h p1=%h",
                 tag, i, id_valid, id_pc, id_inst, id_pc_plus1, ep, mem_val(ep), ep + 8'h01);
      end
    end
  endtask

  task automatic test_redirect_stall();
    // Fill the hold buffer, then redirect while still stalling.
    stall = 1'b1;
    step(); step();
    test_redirect(8'h80, 1'b1, "redir_midstall");
    test_redirect(8'h20, 1'b1, "redir_and_stall");
  endtask

  task automatic test_wrap();
    test_redirect(8'hFE, 1'b0, "wrap");
    for (int i = 0; i < 2; i++) begin
      logic [7:0] ep;
      ep = 8'(i);
      step();
      n_cmp++;
      if ({id_valid, id_pc, id_inst, id_pc_plus1} !== {1'b1, ep, mem_val(ep), ep + 8'h01}) begin
        n_err++;
        $display("FAIL wrap_after[%0d]: got v=%b pc=%h inst=%h p1=%h, want v=1 pc=%h inst=%h p1=%h",
                 i, id_valid, id_pc, id_inst, id_pc_plus1, ep, mem_val(ep), ep + 8'h01);
      end
    end
  endtask

  task automatic test_reset_during_stall();
    stall = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; stall = 1'b0;
    n_cmp++;
    if ({id_valid, imem_addr} !== {1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL rst_stall_clear: got v=%b addr=%h, want v=0 addr=00", id_valid, imem_addr);
    end
    step();
    n_cmp++;
    if (id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_stall_edge1: got v=%b, want 0", id_valid);
    end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] ep;
      ep = 8'(i);
      step();
      n_cmp++;
      if ({id_valid, id_pc, id_inst} !== {1'b1, ep, mem_val(ep)}) begin
        n_err++;
        $display("FAIL rst_stall_restart[%0d]: got v=%b pc=%h inst=%h, want v=1 pc=%h inst=%h",
                 i, id_valid, id_pc, id_inst, ep, mem_val(ep));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect(8'h40, 1'b0, "redirect");
    test_redirect_stall();
    test_wrap();
    test_reset_during_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
